spi_cfg_sequencer: RTL and testbench

- Sequencer and owner of a single spi_master instance (24-bit MOSI word, 8-bit MISO, 16-bit instruction header, word bit 23 = read flag).
- After reset it plays a fixed register-init table out over SPI. It then grants the SPI master to one host requester for single read/write transactions.
- Sits between board-level config logic and spi_master, in the sys_clk domain.

---
 rtl/spi_seq_pkg.sv | 29 ++
 rtl/spi_cfg_rom.sv | 39 +++
 rtl/spi_cfg_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_spi_cfg_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared types and constants for the SPI configuration sequencer.
// SPI_SEQ_READBACK_VERIFY_EN adds the readback-verify states to the state type.
package spi_seq_pkg;

    localparam int unsigned RD_FLAG_BIT  = 23;
    localparam logic [7:0]  HOST_ERR_IDX = 8'hFF;

    typedef logic [23:0] spi_word_t;

    typedef enum logic [3:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        NEXT,
        READY,
        H_ISSUE,
        H_WAIT_HI,
        H_WAIT_LO,
        ERROR
`ifdef SPI_SEQ_READBACK_VERIFY_EN
        ,
        V_ISSUE,
        V_WAIT_HI,
        V_WAIT_LO
`endif
    } seq_state_t;

endpackage

// File: rtl/spi_cfg_rom.sv
// spi_cfg_rom: fixed register-init table played out by spi_cfg_sequencer.
// Each word is {read_flag, addr[14:0], data[7:0]}; indices at or beyond
// NUM_ENTRIES read as zero.
module spi_cfg_rom
    import spi_seq_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 16
) (
    input  logic [7:0] idx,
    output spi_word_t  word
);

    // Table lookup
    always_comb begin
        word = '0;
        if (32'(idx) < NUM_ENTRIES) begin
            case (idx)
                8'd0:    word = 24'h5aa5cf;
                8'd1:    word = 24'h012345;
                8'd2:    word = 24'h80a500;
                8'd3:    word = 24'h02c3f0;
                8'd4:    word = 24'h031011;
                8'd5:    word = 24'h031122;
                8'd6:    word = 24'h031233;
                8'd7:    word = 24'h831300;
                8'd8:    word = 24'h040144;
                8'd9:    word = 24'h040255;
                8'd10:   word = 24'h040366;
                8'd11:   word = 24'h050077;
                8'd12:   word = 24'h050188;
                8'd13:   word = 24'h850100;
                8'd14:   word = 24'h06ff99;
                8'd15:   word = 24'h07ffaa;
                default: word = '0;
            endcase
        end
    end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: owns one spi_master. After reset it plays the init table
// from spi_cfg_rom, then grants the master to a single host requester.
// Optional: define SPI_SEQ_READBACK_VERIFY_EN to read back and compare every
// init write before advancing to the next entry.
module spi_cfg_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES  = 16,
    parameter int unsigned BUSY_TIMEOUT = 64,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    output logic        init_done,
    output logic        init_err,
    output logic [7:0]  err_idx,
    input  logic        host_req,
    input  logic        host_rnw,
    input  logic [23:0] host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        spi_wr_cmd,
    output logic        spi_rd_cmd,
    input  logic        spi_busy,
    output logic [23:0] spi_wr_data,
    input  logic [7:0]  spi_rd_data
);

    localparam int unsigned TMO_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]       LAST_IDX = 8'(NUM_ENTRIES - 1);

    seq_state_t       state, state_nxt;
    logic [7:0]       idx, idx_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    spi_word_t        rom_word;

    logic             wr_cmd_nxt, rd_cmd_nxt, ack_nxt;
    logic             done_nxt, err_nxt;
    logic [7:0]       err_idx_nxt, rdata_nxt;
    spi_word_t        wr_data_nxt;
    logic             go_err, do_start;
    logic [7:0]       go_err_idx;

    spi_cfg_rom #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_rom (
        .idx  (idx),
        .word (rom_word)
    );

    // Next-state and next-output logic; all outputs are registered below
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        tmo_nxt     = '0;
        wr_cmd_nxt  = 1'b0;
        rd_cmd_nxt  = 1'b0;
        wr_data_nxt = spi_wr_data;
        ack_nxt     = 1'b0;
        rdata_nxt   = host_rdata;
        done_nxt    = init_done;
        err_nxt     = init_err;
        err_idx_nxt = err_idx;
        go_err      = 1'b0;
        go_err_idx  = idx;
        do_start    = 1'b0;

        unique case (state)
            IDLE: begin
                if (AUTO_START || start) begin
                    do_start = 1'b1;
                end
            end
            ISSUE: begin
                wr_data_nxt = rom_word;
                if (rom_word[RD_FLAG_BIT]) begin
                    rd_cmd_nxt = 1'b1;
                end else begin
                    wr_cmd_nxt = 1'b1;
                end
                state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (spi_busy) begin
                    state_nxt = WAIT_LO;
                end else if (tmo_cnt == TMO_LAST) begin
                    go_err = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            WAIT_LO: begin
                if (!spi_busy) begin
`ifdef SPI_SEQ_READBACK_VERIFY_EN
                    state_nxt = spi_wr_data[RD_FLAG_BIT] ? NEXT : V_ISSUE;
`else
                    state_nxt = NEXT;
`endif
                end else if (tmo_cnt == TMO_LAST) begin
                    go_err = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
`ifdef SPI_SEQ_READBACK_VERIFY_EN
            V_ISSUE: begin
                wr_data_nxt              = rom_word;
                wr_data_nxt[RD_FLAG_BIT] = 1'b1;
                wr_data_nxt[7:0]         = '0;
                rd_cmd_nxt               = 1'b1;
                state_nxt                = V_WAIT_HI;
            end
            V_WAIT_HI: begin
                if (spi_busy) begin
                    state_nxt = V_WAIT_LO;
                end else if (tmo_cnt == TMO_LAST) begin
                    go_err = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            V_WAIT_LO: begin
                if (!spi_busy) begin
                    if (spi_rd_data != rom_word[7:0]) begin
                        go_err = 1'b1;
                    end else begin
                        state_nxt = NEXT;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    go_err = 1'b1;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
`endif
            NEXT: begin
                if (idx == LAST_IDX) begin
                    done_nxt  = 1'b1;
                    state_nxt = READY;
                end else begin
                    idx_nxt   = idx + 8'd1;
                    state_nxt = ISSUE;
                end
            end
            READY: begin
                // start has priority; a concurrent host_req simply stays pending
                if (start) begin
                    do_start = 1'b1;
                end else if (host_req) begin
                    state_nxt = H_ISSUE;
                end
            end
            H_ISSUE: begin
                wr_data_nxt              = host_wdata;
                wr_data_nxt[RD_FLAG_BIT] = host_rnw;
                if (host_rnw) begin
                    rd_cmd_nxt = 1'b1;
                end else begin
                    wr_cmd_nxt = 1'b1;
                end
                state_nxt = H_WAIT_HI;
            end
            H_WAIT_HI: begin
                if (spi_busy) begin
                    state_nxt = H_WAIT_LO;
                end else if (tmo_cnt == TMO_LAST) begin
                    go_err     = 1'b1;
                    go_err_idx = HOST_ERR_IDX;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            H_WAIT_LO: begin
                if (!spi_busy) begin
                    ack_nxt = 1'b1;
                    if (host_rnw) begin
                        rdata_nxt = spi_rd_data;
                    end
                    state_nxt = READY;
                end else if (tmo_cnt == TMO_LAST) begin
                    go_err     = 1'b1;
                    go_err_idx = HOST_ERR_IDX;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_W'(1);
                end
            end
            ERROR: begin
                if (start) begin
                    do_start = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (do_start) begin
            idx_nxt   = '0;
            done_nxt  = 1'b0;
            err_nxt   = 1'b0;
            state_nxt = ISSUE;
        end

        if (go_err) begin
            err_nxt     = 1'b1;
            done_nxt    = 1'b0;
            err_idx_nxt = go_err_idx;
            state_nxt   = ERROR;
        end
    end

    // State, index, timeout and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            idx         <= '0;
            tmo_cnt     <= '0;
            spi_wr_cmd  <= 1'b0;
            spi_rd_cmd  <= 1'b0;
            spi_wr_data <= '0;
            host_ack    <= 1'b0;
            host_rdata  <= '0;
            init_done   <= 1'b0;
            init_err    <= 1'b0;
            err_idx     <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            tmo_cnt     <= tmo_nxt;
            spi_wr_cmd  <= wr_cmd_nxt;
            spi_rd_cmd  <= rd_cmd_nxt;
            spi_wr_data <= wr_data_nxt;
            host_ack    <= ack_nxt;
            host_rdata  <= rdata_nxt;
            init_done   <= done_nxt;
            init_err    <= err_nxt;
            err_idx     <= err_idx_nxt;
        end
    end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb_spi_cfg_sequencer: randomized bench for spi_cfg_sequencer. The SPI slave
// is modelled as a byte register file addressed by word[22:8]; every command
// the DUT issues is matched against an expected-command queue built from the
// init table and host requests.
module tb_spi_cfg_sequencer;

    localparam int unsigned N_ENT = 4;
    localparam int unsigned TMO   = 16;

    typedef struct packed {
        logic        rd;
        logic [23:0] word;
    } cmd_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst, start, host_req, host_rnw, spi_busy;
    logic [23:0] host_wdata, spi_wr_data;
    logic [7:0]  spi_rd_data, err_idx, host_rdata;
    logic        init_done, init_err, host_ack, spi_wr_cmd, spi_rd_cmd;

    int total = 0;
    int bad   = 0;
    int cyc = 0, cmd_cnt = 0, last_cmd_cyc = 0, last_fall_cyc = 0, ack_cnt = 0;
    int stuck_num = -1, corrupt_num = -1;

    logic [23:0] tbl [N_ENT];
    logic [7:0]  mem [logic [14:0]];
    cmd_t        exp_q [$];

    spi_cfg_sequencer #(
        .NUM_ENTRIES (N_ENT),
        .BUSY_TIMEOUT(TMO),
        .AUTO_START  (1'b1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .init_done  (init_done),
        .init_err   (init_err),
        .err_idx    (err_idx),
        .host_req   (host_req),
        .host_rnw   (host_rnw),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .spi_wr_cmd (spi_wr_cmd),
        .spi_rd_cmd (spi_rd_cmd),
        .spi_busy   (spi_busy),
        .spi_wr_data(spi_wr_data),
        .spi_rd_data(spi_rd_data)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;
    always @(negedge sys_clk) if (host_ack) ack_cnt++;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic cmd_t mk_cmd(input logic rd, input logic [23:0] w);
        cmd_t c;
        c.rd   = rd;
        c.word = w;
        return c;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [14:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // Expected command stream for init entries 0..n-1
    task automatic push_init(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mk_cmd(tbl[i][23], tbl[i]));
`ifdef SPI_SEQ_READBACK_VERIFY_EN
            if (!tbl[i][23])
                exp_q.push_back(mk_cmd(1'b1, {1'b1, tbl[i][22:8], 8'h00}));
`endif
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!init_done && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        chk_eq({tag, "_done"}, init_done, 1);
        chk_eq({tag, "_done_lat"}, cyc - last_fall_cyc, 2);
        chk_eq({tag, "_err"}, init_err, 0);
        chk_eq({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_err(input string tag);
        int n = 0;
        while (!init_err && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        chk_eq({tag, "_err"}, init_err, 1);
        chk_eq({tag, "_done"}, init_done, 0);
    endtask

    task automatic host_txn(input logic rnw, input logic [23:0] w);
        logic [7:0] exp_d;
        int n = 0;
        exp_d = mem_rd(w[22:8]);
        exp_q.push_back(mk_cmd(rnw, {rnw, w[22:0]}));
        host_req   = 1'b1;
        host_rnw   = rnw;
        host_wdata = w;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!host_ack && n < 200);
        chk_eq("host_ack", host_ack, 1);
        chk_eq("host_ack_lat", cyc - last_fall_cyc, 1);
        if (rnw) chk_eq("host_rdata", host_rdata, exp_d);
        host_req = 1'b0;
        @(negedge sys_clk);
        chk_eq("host_ack_pulse", host_ack, 0);
    endtask

    // SPI slave: checks each command against the queue, then busy-handshakes
    initial begin : slave
        cmd_t       e;
        logic [7:0] d;
        spi_busy    = 1'b0;
        spi_rd_data = '0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && (spi_wr_cmd || spi_rd_cmd)) begin
                cmd_cnt++;
                last_cmd_cyc = cyc;
                chk_eq("cmd_pending", exp_q.size() > 0, 1);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                chk_eq("cmd_kind", {spi_rd_cmd, spi_wr_cmd}, {e.rd, ~e.rd});
                chk_eq("cmd_word", spi_wr_data, e.word);
                @(negedge sys_clk);
                chk_eq("cmd_pulse", spi_wr_cmd | spi_rd_cmd, 0);
                if (cmd_cnt != stuck_num) begin
                    repeat ($urandom_range(0, 3)) @(negedge sys_clk);
                    spi_busy = 1'b1;
                    repeat ($urandom_range(1, 5)) @(negedge sys_clk);
                    if (e.rd) begin
                        d = mem_rd(e.word[22:8]);
                        if (cmd_cnt == corrupt_num) d = ~d;
                        spi_rd_data = d;
                    end else begin
                        mem[e.word[22:8]] = e.word[7:0];
                    end
                    chk_eq("wr_data_hold", spi_wr_data, e.word);
                    spi_busy      = 1'b0;
                    last_fall_cyc = cyc;
                end
            end
        end
    end

    initial begin : main
        int base, n0, acks0, n, done_cyc;
        logic [14:0] addrs [4];
        logic [7:0]  exp_d;
        tbl[0] = 24'h5aa5cf;
        tbl[1] = 24'h012345;
        tbl[2] = 24'h80a500;
        tbl[3] = 24'h02c3f0;
        addrs[0] = 15'h0010; addrs[1] = 15'h0011; addrs[2] = 15'h00a5; addrs[3] = 15'h5aa5;
`ifdef SPI_SEQ_READBACK_VERIFY_EN
        n0 = tbl[0][23] ? 1 : 2;
`else
        n0 = 1;
`endif
        sys_rst = 1'b1; start = 1'b0; host_req = 1'b0; host_rnw = 1'b0; host_wdata = '0;
        repeat (3) @(negedge sys_clk);
        chk_eq("rst_done", init_done, 0);
        chk_eq("rst_err", init_err, 0);
        chk_eq("rst_err_idx", err_idx, 0);
        chk_eq("rst_cmds", {spi_wr_cmd, spi_rd_cmd}, 0);
        chk_eq("rst_wdata", spi_wr_data, 0);
        chk_eq("rst_ack", host_ack, 0);
        chk_eq("rst_rdata", host_rdata, 0);

        // Auto-started init run
        push_init(N_ENT);
        n = exp_q.size();
        sys_rst = 1'b0;
        wait_done("init1");
        chk_eq("init1_cmd_cnt", cmd_cnt, n);

        // Directed host read
        mem[15'h00a5] = 8'h3c;
        host_txn(1'b1, 24'h00a5ca);

        // Random host traffic against the register-file model
        for (int i = 0; i < 12; i++) begin
            host_txn(1'($urandom_range(0, 1)),
                     {1'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)], 8'($urandom)});
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        end

        // Busy never rises for entry 1: timeout, host locked out, then rerun
        base      = cmd_cnt;
        stuck_num = base + n0 + 1;
        push_init(1);
        exp_q.push_back(mk_cmd(tbl[1][23], tbl[1]));
        acks0 = ack_cnt;
        pulse_start();
        chk_eq("restart_clr_done", init_done, 0);
        host_req = 1'b1; host_rnw = 1'b0; host_wdata = 24'h001155;
        wait_err("stuck");
        chk_eq("stuck_tmo_lat", cyc - last_cmd_cyc, TMO);
        chk_eq("stuck_err_idx", err_idx, 1);
        repeat (30) @(negedge sys_clk);
        chk_eq("stuck_no_ack", ack_cnt - acks0, 0);
        chk_eq("stuck_no_cmds", cmd_cnt - base, n0 + 1);
        chk_eq("stuck_err_hold", init_err, 1);
        host_req  = 1'b0;
        stuck_num = -1;
        push_init(N_ENT);
        pulse_start();
        chk_eq("rerun_clr_err", init_err, 0);
        wait_done("rerun");

        // start and host_req together in READY: init first, then host
        exp_d = mem_rd(15'h00a5);
        push_init(N_ENT);
        exp_q.push_back(mk_cmd(1'b1, 24'h80a5ca));
        host_req = 1'b1; host_rnw = 1'b1; host_wdata = 24'h00a5ca;
        pulse_start();
        chk_eq("arb_clr_done", init_done, 0);
        done_cyc = -1;
        n = 0;
        while (!host_ack && n < 2000) begin
            if (init_done && done_cyc < 0) done_cyc = cyc;
            @(negedge sys_clk);
            n++;
        end
        chk_eq("arb_ack", host_ack, 1);
        chk_eq("arb_done_first", (done_cyc >= 0) && (done_cyc < cyc), 1);
        chk_eq("arb_ack_lat", cyc - last_fall_cyc, 1);
        chk_eq("arb_rdata", host_rdata, exp_d);
        chk_eq("arb_q_empty", exp_q.size(), 0);
        host_req = 1'b0;
        @(negedge sys_clk);

`ifdef SPI_SEQ_READBACK_VERIFY_EN
        // Wrong readback for entry 0 stops the sequence
        base        = cmd_cnt;
        corrupt_num = base + 2;
        push_init(1);
        pulse_start();
        wait_err("rbv");
        chk_eq("rbv_err_idx", err_idx, 0);
        repeat (30) @(negedge sys_clk);
        chk_eq("rbv_no_cmds", cmd_cnt - base, 2);
        corrupt_num = -1;
`endif

        repeat (5) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
